traffic_light_monitor: RTL and testbench

Passive checker on the receiving end of the traffic-light controller's lamp outputs. It samples the red/yellow/green lines every clock, locks onto the phase sequence RED → YELLOW → GREEN → YELLOW → RED, and checks each phase's hold time against its parameter. It reports protocol violations and counts completed cycles. It sits beside the controller in the lab top level and in the controller's testbench as a self-checking observer.

---
 rtl/traffic_light_monitor.sv | 136 +++++++++++++
 tb/tb_traffic_light_monitor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive observer of a traffic-light controller's lamp lines: locks onto the
// RED -> YEL1 -> GREEN -> YEL2 sequence, checks hold times and counts cycles.
module traffic_light_monitor #(
  parameter int RED       = 1,
  parameter int YELLOW    = 5,
  parameter int GREEN     = 7,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_red,
  input  logic                 i_yellow,
  input  logic                 i_green,
  output logic                 o_locked,
  output logic [2:0]           o_phase,
  output logic                 o_err,
  output logic [2:0]           o_err_code,
  output logic [CNT_WIDTH-1:0] o_cycle_cnt
);

  localparam int MAX_RY  = (RED > YELLOW) ? RED : YELLOW;
  localparam int MAX_DUR = (MAX_RY > GREEN) ? MAX_RY : GREEN;
  localparam int DUR_W   = $clog2(MAX_DUR + 1);

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  localparam logic [2:0] E_SHORT   = 3'd1;
  localparam logic [2:0] E_LONG    = 3'd2;
  localparam logic [2:0] E_ORDER   = 3'd3;
  localparam logic [2:0] E_ILLEGAL = 3'd4;
  localparam logic [2:0] E_DARK    = 3'd5;

  typedef enum logic [2:0] {
    ST_SYNC  = 3'd0,
    ST_RED   = 3'd1,
    ST_YEL1  = 3'd2,
    ST_GREEN = 3'd3,
    ST_YEL2  = 3'd4
  } state_t;

  state_t               state, state_nxt, succ_state;
  logic [DUR_W-1:0]     dur, dur_nxt, exp_dur;
  logic                 prev_red;
  logic                 err, err_nxt;
  logic [2:0]           err_code, code_nxt, err_val;
  logic [CNT_WIDTH-1:0] cycle_cnt, cnt_nxt;
  logic [2:0]           lamps, cur_lamp, next_lamp;
  logic                 hit;

  assign lamps = {i_red, i_yellow, i_green};

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state     <= ST_SYNC;
      dur       <= '0;
      prev_red  <= 1'b1;
      err       <= 1'b0;
      err_code  <= '0;
      cycle_cnt <= '0;
    end else begin
      state     <= state_nxt;
      dur       <= dur_nxt;
      prev_red  <= i_red;
      err       <= err_nxt;
      err_code  <= code_nxt;
      cycle_cnt <= cnt_nxt;
    end
  end

  // Per-phase lamp, successor lamp/state and required hold time.
  always_comb begin
    cur_lamp   = 3'b000;
    next_lamp  = 3'b000;
    exp_dur    = '0;
    succ_state = ST_SYNC;
    case (state)
      ST_RED:   begin cur_lamp = L_RED; next_lamp = L_YEL; exp_dur = DUR_W'(RED);    succ_state = ST_YEL1;  end
      ST_YEL1:  begin cur_lamp = L_YEL; next_lamp = L_GRN; exp_dur = DUR_W'(YELLOW); succ_state = ST_GREEN; end
      ST_GREEN: begin cur_lamp = L_GRN; next_lamp = L_YEL; exp_dur = DUR_W'(GREEN);  succ_state = ST_YEL2;  end
      ST_YEL2:  begin cur_lamp = L_YEL; next_lamp = L_RED; exp_dur = DUR_W'(YELLOW); succ_state = ST_RED;   end
      default:  ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    dur_nxt   = dur;
    err_nxt   = 1'b0;
    code_nxt  = err_code;
    cnt_nxt   = cycle_cnt;
    hit       = 1'b0;
    err_val   = '0;
    if (state == ST_SYNC) begin
      if (lamps == L_RED && !prev_red) begin
        state_nxt = ST_RED;
        dur_nxt   = DUR_W'(1);
      end
    end else begin
      if (!$onehot0(lamps)) begin
        hit = 1'b1; err_val = E_ILLEGAL;
      end else if (lamps == 3'b000) begin
        hit = 1'b1; err_val = E_DARK;
      end else if (lamps == cur_lamp) begin
        if (dur == exp_dur) begin
          hit = 1'b1; err_val = E_LONG;
        end else begin
          dur_nxt = dur + DUR_W'(1);
        end
      end else if (lamps != next_lamp) begin
        hit = 1'b1; err_val = E_ORDER;
      end else if (dur < exp_dur) begin
        hit = 1'b1; err_val = E_SHORT;
      end else begin
        state_nxt = succ_state;
        dur_nxt   = DUR_W'(1);
        if (state == ST_YEL2) cnt_nxt = cycle_cnt + CNT_WIDTH'(1);
      end
      // Dropping to SYNC with prev_red tracking forces a fresh red edge to re-lock.
      if (hit) begin
        err_nxt   = 1'b1;
        code_nxt  = err_val;
        state_nxt = ST_SYNC;
        dur_nxt   = '0;
      end
    end
  end

  assign o_locked    = (state != ST_SYNC);
  assign o_phase     = state;
  assign o_err       = err;
  assign o_err_code  = err_code;
  assign o_cycle_cnt = cycle_cnt;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench: default-parameter monitor plus a CNT_WIDTH=2 copy for wrap checks.
module tb_traffic_light_monitor;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_red = 1'b0, i_yellow = 1'b0, i_green = 1'b0;
  logic        o_locked, o_err, w_locked, w_err;
  logic [2:0]  o_phase, o_err_code, w_phase, w_err_code;
  logic [15:0] o_cycle_cnt;
  logic [1:0]  w_cycle_cnt;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, D = 3'b000, RY = 3'b110;

  always #5 clk = ~clk;

  traffic_light_monitor dut (
    .clk(clk), .i_rst(i_rst), .i_red(i_red), .i_yellow(i_yellow), .i_green(i_green),
    .o_locked(o_locked), .o_phase(o_phase), .o_err(o_err),
    .o_err_code(o_err_code), .o_cycle_cnt(o_cycle_cnt)
  );

  traffic_light_monitor #(.CNT_WIDTH(2)) dut_w (
    .clk(clk), .i_rst(i_rst), .i_red(i_red), .i_yellow(i_yellow), .i_green(i_green),
    .o_locked(w_locked), .o_phase(w_phase), .o_err(w_err),
    .o_err_code(w_err_code), .o_cycle_cnt(w_cycle_cnt)
  );

  task automatic apply_stimulus(input logic rst, input logic [2:0] lamps);
    @(negedge clk);
    i_rst = rst;
    {i_red, i_yellow, i_green} = lamps;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Hold one lamp for n samples, expecting to stay in phase ph without errors.
  task automatic hold(input logic [2:0] lamps, input int n, input int ph);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1'b0, lamps);
      check_output("hold_phase", o_phase, ph);
      check_output("hold_err", o_err, 0);
    end
  endtask

  task automatic tail();
    hold(Y, 5, 2);
    hold(G, 7, 3);
    hold(Y, 5, 4);
  endtask

  int exp_wrap[5] = '{1, 2, 3, 0, 1};

  initial begin
    // Reset state
    apply_stimulus(1'b1, D);
    check_output("rst_locked", o_locked, 0);
    check_output("rst_phase", o_phase, 0);
    check_output("rst_err", o_err, 0);
    check_output("rst_code", o_err_code, 0);
    check_output("rst_cnt", o_cycle_cnt, 0);

    // Nominal sequence
    hold(D, 2, 0);
    apply_stimulus(1'b0, R);
    check_output("nom_lock", o_locked, 1);
    check_output("nom_phase_red", o_phase, 1);
    for (int k = 1; k <= 3; k++) begin
      tail();
      apply_stimulus(1'b0, R);
      check_output("nom_phase_red", o_phase, 1);
      check_output("nom_err", o_err, 0);
      check_output("nom_cnt", o_cycle_cnt, k);
    end

    // Short green
    hold(Y, 5, 2);
    hold(G, 6, 3);
    apply_stimulus(1'b0, Y);
    check_output("short_err", o_err, 1);
    check_output("short_code", o_err_code, 1);
    check_output("short_locked", o_locked, 0);
    apply_stimulus(1'b0, D);
    check_output("short_err_pulse", o_err, 0);
    check_output("short_code_hold", o_err_code, 1);

    // ORDER: red followed directly by green
    apply_stimulus(1'b0, R);
    check_output("order_relock", o_locked, 1);
    apply_stimulus(1'b0, G);
    check_output("order_err", o_err, 1);
    check_output("order_code", o_err_code, 3);
    check_output("order_locked", o_locked, 0);

    // ILLEGAL while locked, then red held through the error must not re-lock
    apply_stimulus(1'b0, D);
    apply_stimulus(1'b0, R);
    check_output("ill_lock", o_locked, 1);
    apply_stimulus(1'b0, RY);
    check_output("ill_err", o_err, 1);
    check_output("ill_code", o_err_code, 4);
    apply_stimulus(1'b0, R);
    check_output("held_red_nolock", o_locked, 0);
    check_output("held_red_noerr", o_err, 0);
    apply_stimulus(1'b0, RY);
    check_output("sync_ill_noerr", o_err, 0);
    check_output("sync_ill_phase", o_phase, 0);
    check_output("sync_ill_code", o_err_code, 4);

    // Long yellow
    apply_stimulus(1'b0, D);
    apply_stimulus(1'b0, R);
    check_output("long_lock", o_phase, 1);
    hold(Y, 5, 2);
    apply_stimulus(1'b0, Y);
    check_output("long_err", o_err, 1);
    check_output("long_code", o_err_code, 2);
    check_output("long_locked", o_locked, 0);

    // DARK while locked
    apply_stimulus(1'b0, D);
    apply_stimulus(1'b0, R);
    check_output("dark_lock", o_locked, 1);
    apply_stimulus(1'b0, D);
    check_output("dark_err", o_err, 1);
    check_output("dark_code", o_err_code, 5);

    // Reset mid-operation during GREEN with two completed cycles
    apply_stimulus(1'b1, D);
    apply_stimulus(1'b0, D);
    apply_stimulus(1'b0, R);
    for (int k = 1; k <= 2; k++) begin
      tail();
      apply_stimulus(1'b0, R);
    end
    hold(Y, 5, 2);
    hold(G, 3, 3);
    check_output("mid_cnt_before", o_cycle_cnt, 2);
    apply_stimulus(1'b1, G);
    check_output("mid_locked", o_locked, 0);
    check_output("mid_phase", o_phase, 0);
    check_output("mid_err", o_err, 0);
    check_output("mid_code", o_err_code, 0);
    check_output("mid_cnt", o_cycle_cnt, 0);
    apply_stimulus(1'b0, D);
    apply_stimulus(1'b0, R);
    check_output("mid_relock", o_locked, 1);
    tail();
    apply_stimulus(1'b0, R);
    check_output("mid_cnt_restart", o_cycle_cnt, 1);

    // Counter wrap on the narrow-counter instance
    apply_stimulus(1'b1, D);
    check_output("wrap_rst_cnt", w_cycle_cnt, 0);
    apply_stimulus(1'b0, D);
    apply_stimulus(1'b0, R);
    check_output("wrap_lock", w_locked, 1);
    for (int k = 0; k < 5; k++) begin
      tail();
      apply_stimulus(1'b0, R);
      check_output("wrap_cnt", w_cycle_cnt, exp_wrap[k]);
      check_output("wrap_err", w_err, 0);
      check_output("wrap_code", w_err_code, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
